// File: rtl/prog_loader_pkg.sv
// Shared types and widths for the instruction-memory program loader.
package prog_loader_pkg;

  localparam int WORD_W = 32;
  localparam int BYTE_W = 8;
  localparam int LEN_W  = 16;

  typedef enum logic [2:0] {
    LEN_LO = 3'd0,
    LEN_HI = 3'd1,
    DATA   = 3'd2,
    CKSUM  = 3'd3,
    RUN    = 3'd4,
    ERROR  = 3'd5
  } state_t;

  // True for every state in which the loader is willing to take a byte.
  function automatic logic is_load_state(input state_t s);
    logic r;
    r = 1'b0;
    case (s)
      LEN_LO, LEN_HI, DATA, CKSUM: r = 1'b1;
      default:                     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/prog_loader_asm.sv
// Byte-to-word assembler: collects four bytes little-endian and emits a
// one-cycle word_valid pulse together with the finished 32-bit word.
module prog_loader_asm
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [1:0]        byte_idx,
  output logic              word_valid,
  output logic [WORD_W-1:0] word
);

  logic [3*BYTE_W-1:0] low_bytes;

  // Holds the first three bytes of the word in progress and tracks the byte index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx  <= 2'd0;
      low_bytes <= '0;
    end else if (clear) begin
      byte_idx  <= 2'd0;
    end else if (byte_valid) begin
      case (byte_idx)
        2'd0:    low_bytes[BYTE_W-1:0]          <= byte_in;
        2'd1:    low_bytes[2*BYTE_W-1:BYTE_W]   <= byte_in;
        2'd2:    low_bytes[3*BYTE_W-1:2*BYTE_W] <= byte_in;
        default: ;
      endcase
      byte_idx <= byte_idx + 2'd1;
    end
  end

  // Completes the word on the fourth byte; word stays stable until the next one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (byte_valid && !clear && (byte_idx == 2'd3)) begin
        word_valid <= 1'b1;
        word       <= {byte_in, low_bytes};
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a length-prefixed byte stream, writes the words
// into instruction memory and holds the CPU in reset until loading is done.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              reload,
  output logic              imem_we,
  output logic [AW-1:0]     imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

`ifdef PROG_LOADER_CKSUM_EN
  localparam state_t AFTER_LOAD = CKSUM;
`else
  localparam state_t AFTER_LOAD = RUN;
`endif

  state_t              state;
  state_t              state_next;
  logic                accept;
  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    len_full;
  logic [AW-1:0]       word_cnt;
  logic                last_word;
  logic                load_start;
  logic                restart;
  logic                asm_clear;
  logic                asm_byte_valid;
  logic [1:0]          byte_idx;
  logic                word_valid;
  logic [WORD_W-1:0]   word;
  logic                cks_ok;

  assign accept         = in_valid && in_ready;
  assign len_full       = {in_data, len_q[BYTE_W-1:0]};
  assign last_word      = (LEN_W'(word_cnt) == (len_q - LEN_W'(1)));
  assign load_start     = accept && (state == LEN_HI);
  assign restart        = reload && ((state == RUN) || (state == ERROR));
  assign asm_clear      = load_start || restart;
  assign asm_byte_valid = accept && (state == DATA);

  prog_loader_asm u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (asm_clear),
    .byte_valid (asm_byte_valid),
    .byte_in    (in_data),
    .byte_idx   (byte_idx),
    .word_valid (word_valid),
    .word       (word)
  );

`ifdef PROG_LOADER_CKSUM_EN
  logic [BYTE_W-1:0] cks_q;

  // Running XOR of every accepted byte, restarted by the first length byte.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cks_q <= '0;
    end else if (accept) begin
      case (state)
        LEN_LO:       cks_q <= in_data;
        LEN_HI, DATA: cks_q <= cks_q ^ in_data;
        default:      ;
      endcase
    end
  end

  assign cks_ok = (in_data == cks_q);
`else
  assign cks_ok = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= LEN_LO;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; the final word's write cycle already sits in AFTER_LOAD.
  always_comb begin
    state_next = state;
    case (state)
      LEN_LO: begin
        if (accept) state_next = LEN_HI;
      end
      LEN_HI: begin
        if (accept) begin
          if (len_full > LEN_W'(DEPTH)) begin
            state_next = ERROR;
          end else if (len_full == '0) begin
            state_next = AFTER_LOAD;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        if (asm_byte_valid && (byte_idx == 2'd3) && last_word) begin
          state_next = AFTER_LOAD;
        end
      end
      CKSUM: begin
        if (accept) state_next = cks_ok ? RUN : ERROR;
      end
      RUN, ERROR: begin
        if (reload) state_next = LEN_LO;
      end
      default: state_next = LEN_LO;
    endcase
  end

  // Ready follows the upcoming state so it stays low through reset and the first cycle after.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready <= 1'b0;
    end else begin
      in_ready <= is_load_state(state_next);
    end
  end

  // Captures the two length bytes, low byte first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q <= '0;
    end else if (accept && (state == LEN_LO)) begin
      len_q[BYTE_W-1:0] <= in_data;
    end else if (accept && (state == LEN_HI)) begin
      len_q[LEN_W-1:BYTE_W] <= in_data;
    end
  end

  // Word address; advances after each non-final write so it never wraps past DEPTH-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (asm_clear) begin
      word_cnt <= '0;
    end else if (word_valid && (state == DATA)) begin
      word_cnt <= word_cnt + AW'(1);
    end
  end

  // CPU reset release lags RUN entry by a cycle and drops as soon as reload is seen.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_rst <= 1'b0;
    end else begin
      cpu_rst <= (state == RUN) && !reload;
    end
  end

  assign imem_we    = word_valid;
  assign imem_addr  = word_cnt;
  assign imem_wdata = word;
  assign done       = (state == RUN);
  assign err        = (state == ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader; covers both builds of PROG_LOADER_CKSUM_EN.
module tb_prog_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          reload = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;
  int readyLow = 0;

  logic [AW-1:0] wrAddr[$];
  logic [31:0]   wrData[$];

  prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .reload     (reload),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .err        (err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Logs every memory write cycle away from the active edge.
  always @(negedge clk) begin
    if (imem_we) begin
      wrAddr.push_back(imem_addr);
      wrData.push_back(imem_wdata);
    end
  end

  // Hard stop in case something never settles.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Offers one byte from a negedge and returns on the negedge after it was accepted.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    readyLow += waited;
    if (waited >= 50) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < gap; i++) begin
      if (!in_ready) readyLow++;
      @(negedge clk);
    end
  endtask

  // Sends n bytes taken from vec, most significant byte first.
  task automatic sendStream(input logic [127:0] vec, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(vec[8*(n-1-i) +: 8], (i == n - 1) ? 0 : gap);
    end
  endtask

  task automatic pulseReload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
  endtask

  // Closes a load (checksum byte if built in) and checks the RUN entry and cpu_rst timing.
  task automatic finishLoad(input logic [7:0] cks, input string tag, input logic expectWrite);
    logic expWe;
    $display("[TB] %s closing load, checksum byte 0x%02h", tag, cks);
`ifdef PROG_LOADER_CKSUM_EN
    applyStimulus(cks, 0);
    expWe = 1'b0;
`else
    expWe = expectWrite;
`endif
    checkOutput({tag, "_final_we"}, {31'd0, imem_we}, {31'd0, expWe});
    checkOutput({tag, "_done"}, {31'd0, done}, 32'd1);
    checkOutput({tag, "_cpurst_lo"}, {31'd0, cpu_rst}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_cpurst_hi"}, {31'd0, cpu_rst}, 32'd1);
    checkOutput({tag, "_we_off"}, {31'd0, imem_we}, 32'd0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_imem_we", {31'd0, imem_we}, 32'd0);
    checkOutput("rst_imem_addr", {24'd0, imem_addr}, 32'd0);
    checkOutput("rst_imem_wdata", imem_wdata, 32'd0);
    checkOutput("rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_err", {31'd0, err}, 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Two-word load, back to back.
    clearLog();
    sendStream(128'h0200_1300_0000_EFBE_ADDE, 10, 0);
    finishLoad(8'h33, "t1", 1'b1);
    checkOutput("t1_nwr", wrAddr.size(), 32'd2);
    checkOutput("t1_addr0", {24'd0, wrAddr[0]}, 32'd0);
    checkOutput("t1_data0", wrData[0], 32'h0000_0013);
    checkOutput("t1_addr1", {24'd0, wrAddr[1]}, 32'd1);
    checkOutput("t1_data1", wrData[1], 32'hDEAD_BEEF);

    // Same stream with a gap after every byte.
    pulseReload();
    checkOutput("t2_reload_cpurst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t2_reload_done", {31'd0, done}, 32'd0);
    clearLog();
    readyLow = 0;
    sendStream(128'h0200_1300_0000_EFBE_ADDE, 10, 1);
    checkOutput("t2_ready_low", readyLow, 32'd0);
    finishLoad(8'h33, "t2", 1'b1);
    checkOutput("t2_nwr", wrAddr.size(), 32'd2);
    checkOutput("t2_data0", wrData[0], 32'h0000_0013);
    checkOutput("t2_addr1", {24'd0, wrAddr[1]}, 32'd1);
    checkOutput("t2_data1", wrData[1], 32'hDEAD_BEEF);

    // Oversized length goes to ERROR.
    pulseReload();
    clearLog();
    sendStream(128'h0101, 2, 0);
    checkOutput("t3_err", {31'd0, err}, 32'd1);
    checkOutput("t3_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("t3_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t3_done", {31'd0, done}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("t3_nwr", wrAddr.size(), 32'd0);
    checkOutput("t3_err_held", {31'd0, err}, 32'd1);
    pulseReload();
    checkOutput("t3_reload_err", {31'd0, err}, 32'd0);
    checkOutput("t3_reload_ready", {31'd0, in_ready}, 32'd1);

    // Zero length.
    clearLog();
    sendStream(128'h0000, 2, 0);
`ifdef PROG_LOADER_CKSUM_EN
    checkOutput("t4_wait_cks_done", {31'd0, done}, 32'd0);
    checkOutput("t4_wait_cks_ready", {31'd0, in_ready}, 32'd1);
`endif
    finishLoad(8'h00, "t4", 1'b0);
    checkOutput("t4_nwr", wrAddr.size(), 32'd0);

    // Reload from RUN and load a single word.
    pulseReload();
    checkOutput("t5_reload_cpurst", {31'd0, cpu_rst}, 32'd0);
    clearLog();
    sendStream(128'h0100_4433_2211, 6, 0);
    finishLoad(8'h45, "t5", 1'b1);
    checkOutput("t5_nwr", wrAddr.size(), 32'd1);
    checkOutput("t5_addr0", {24'd0, wrAddr[0]}, 32'd0);
    checkOutput("t5_data0", wrData[0], 32'h1122_3344);

`ifdef PROG_LOADER_CKSUM_EN
    // Checksum good, then bad.
    pulseReload();
    clearLog();
    sendStream(128'h0100_0102_0304, 6, 0);
    finishLoad(8'h05, "t6a", 1'b1);
    checkOutput("t6a_data0", wrData[0], 32'h0403_0201);
    pulseReload();
    clearLog();
    sendStream(128'h0100_0102_0304, 6, 0);
    applyStimulus(8'h06, 0);
    checkOutput("t6b_err", {31'd0, err}, 32'd1);
    checkOutput("t6b_done", {31'd0, done}, 32'd0);
    checkOutput("t6b_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    @(negedge clk);
    checkOutput("t6b_cpu_rst_held", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t6b_nwr", wrAddr.size(), 32'd1);
    checkOutput("t6b_addr0", {24'd0, wrAddr[0]}, 32'd0);
    checkOutput("t6b_data0", wrData[0], 32'h0403_0201);
`endif

    // Asynchronous reset in the middle of a word.
    pulseReload();
    clearLog();
    sendStream(128'h0100_AABB, 4, 0);
    rst = 1'b0;
    #1;
    checkOutput("t7_rst_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t7_rst_we", {31'd0, imem_we}, 32'd0);
    checkOutput("t7_rst_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("t7_nwr_after_rst", wrAddr.size(), 32'd0);
    checkOutput("t7_done", {31'd0, done}, 32'd0);
    checkOutput("t7_err", {31'd0, err}, 32'd0);
    checkOutput("t7_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    checkOutput("t7_ready", {31'd0, in_ready}, 32'd1);
    sendStream(128'h0100_7856_3412, 6, 0);
    finishLoad(8'h09, "t7", 1'b1);
    checkOutput("t7_nwr", wrAddr.size(), 32'd1);
    checkOutput("t7_addr0", {24'd0, wrAddr[0]}, 32'd0);
    checkOutput("t7_data0", wrData[0], 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
